// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants and types for the audio PWM DAC slice:
//               default sample width, midscale code and the player state
//               enumeration.
// Revision    : 1.0  initial release
// ============================================================================
package audio_pkg;

    localparam int SAMPLE_W = 4;

    // Midscale of an unsigned SAMPLE_W-bit sample, i.e. silence.
    localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/audio_pwm_dac_timebase.sv
`default_nettype none
// ============================================================================
// Module      : pwm_timebase
// Description : PWM period timebase. A prescaler divides clk by PRESCALE and
//               each prescaler wrap advances the PWM count, which free-runs
//               through 0..2^CNT_W-1. boundary flags the last clk cycle of a
//               PWM period.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               pwm_cnt       - current PWM count (0 on the cycle after reset)
//               boundary      - high on the final cycle of each period
// Revision    : 1.0  initial release
// ============================================================================
module pwm_timebase #(
    parameter int PRESCALE = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] pwm_cnt,
    output logic             boundary
);

    logic pre_wrap;

    generate
        if (PRESCALE == 1) begin : g_pre_none
            // Every clk is a count step; no prescaler register needed.
            assign pre_wrap = 1'b1;
        end else begin : g_pre_div
            localparam int PRE_W = $clog2(PRESCALE);

            logic [PRE_W-1:0] pre_cnt;

            assign pre_wrap = (pre_cnt == PRE_W'(PRESCALE - 1));

            always_ff @(posedge clk) begin
                if (rst) begin
                    pre_cnt <= '0;
                end else if (pre_wrap) begin
                    pre_cnt <= '0;
                end else begin
                    pre_cnt <= pre_cnt + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (pre_wrap) begin
            pwm_cnt <= pwm_cnt + 1'b1;  // natural wrap at all-ones
        end
    end

    assign boundary = pre_wrap && (pwm_cnt == '1);

endmodule
`default_nettype wire

// File: rtl/audio_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module      : audio_pwm_dac
// Description : Turns an unsigned sample stream into a single-bit PWM signal.
//               Samples enter a one-entry pending buffer (valid/ready), are
//               moved into the active register only at PWM period boundaries,
//               and are attenuated around midscale by an arithmetic shift.
//               Mute and stream starvation both force midscale duty.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               sample_in     - unsigned sample, taken when valid && ready
//               sample_valid  - upstream has a sample
//               sample_ready  - pending buffer empty (registered)
//               volume        - attenuation shift, 0 = full, 3 = /8
//               mute          - force midscale from the next boundary
//               pwm_out       - registered PWM output
//               underrun      - one-cycle pulse on the PLAY->IDLE transition
// Revision    : 1.0  initial release
// ============================================================================
module audio_pwm_dac #(
    parameter int SAMPLE_W        = audio_pkg::SAMPLE_W,
    parameter int PRESCALE        = 8,
    parameter int TIMEOUT_PERIODS = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [1:0]          volume,
    input  logic                mute,
    output logic                pwm_out,
    output logic                underrun
);

    import audio_pkg::*;

    localparam logic [SAMPLE_W-1:0] MID     = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam int                  STARV_W = $clog2(TIMEOUT_PERIODS + 1);

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic [SAMPLE_W-1:0] pwm_cnt;
    logic                boundary;

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .CNT_W    (SAMPLE_W)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .pwm_cnt  (pwm_cnt),
        .boundary (boundary)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state;
    state_t              next_state;
    logic [SAMPLE_W-1:0] pend;
    logic                pend_full;
    logic [SAMPLE_W-1:0] active;
    logic [SAMPLE_W-1:0] duty_reg;
    logic [STARV_W-1:0]  starve_cnt;

    logic                accept;
    logic                transfer;
    logic                timeout_hit;
    logic [SAMPLE_W-1:0] next_active;
    logic [SAMPLE_W-1:0] duty_next;

    // sample_ready is itself a register mirroring !pend_full, so accept
    // never depends combinationally on sample_valid feeding back to ready.
    assign accept = sample_valid && sample_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, boundary actions and next duty
    // ------------------------------------------------------------------
    logic signed [SAMPLE_W-1:0] d_off;
    logic signed [SAMPLE_W-1:0] d_shift;

    always_comb begin
        next_state  = state;
        transfer    = 1'b0;
        timeout_hit = 1'b0;

        if (boundary) begin
            if (pend_full) begin
                transfer   = 1'b1;
                next_state = PLAY;
            end else if ((state == PLAY) &&
                         (starve_cnt == STARV_W'(TIMEOUT_PERIODS - 1))) begin
                // This boundary would bring starve_cnt to TIMEOUT_PERIODS.
                timeout_hit = 1'b1;
                next_state  = IDLE;
            end
        end

        if (transfer) begin
            next_active = pend;
        end else if (timeout_hit) begin
            next_active = MID;
        end else begin
            next_active = active;
        end

        // Subtracting midscale from an unsigned code equals flipping its MSB
        // and reading it as two's complement; the range -MID..MID-1 fits in
        // SAMPLE_W bits, so after the arithmetic shift the same flip adds
        // midscale back without overflow.
        d_off   = $signed({~next_active[SAMPLE_W-1], next_active[SAMPLE_W-2:0]});
        d_shift = d_off >>> volume;

        if (mute || (next_state == IDLE)) begin
            duty_next = MID;
        end else begin
            duty_next = {~d_shift[SAMPLE_W-1], d_shift[SAMPLE_W-2:0]};
        end
    end

    // ------------------------------------------------------------------
    // Buffer, active sample, starvation counter, duty and output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend         <= '0;
            pend_full    <= 1'b0;
            sample_ready <= 1'b1;
            active       <= MID;
            duty_reg     <= MID;
            starve_cnt   <= '0;
            underrun     <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            // accept and transfer are mutually exclusive: transfer needs
            // pend_full, and pend_full holds sample_ready low.
            if (accept) begin
                pend         <= sample_in;
                pend_full    <= 1'b1;
                sample_ready <= 1'b0;
            end else if (transfer) begin
                pend_full    <= 1'b0;
                sample_ready <= 1'b1;
            end

            active <= next_active;

            if (transfer || timeout_hit) begin
                starve_cnt <= '0;
            end else if (boundary && (state == PLAY)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            // Duty for the coming period; volume and mute are sampled here.
            if (boundary) begin
                duty_reg <= duty_next;
            end

            underrun <= timeout_hit;
            pwm_out  <= (pwm_cnt < duty_reg);
        end
    end

endmodule
`default_nettype wire
